sr_latch_bank: RTL and testbench

Parametrised bank of N_CH independent debounced set/reset latches driven by push-buttons. Each channel has a 2-FF synchroniser and tick-based debounce filter on its SET and CLR inputs, plus a configurable priority rule. The latch drives complementary LED outputs. The block runs entirely on the board clock CLK: a prescaler produces a one-cycle clock-enable tick, and no derived clock is used. It sits between the raw button pins and the LED pins at top level.

---
 rtl/sr_latch_pkg.sv | 16 +
 rtl/sr_latch_bank_db_filter.sv | 61 ++++++
 rtl/sr_latch_bank.sv | 101 ++++++++++
 tb/tb_sr_latch_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared constants and helpers for the debounced set/reset latch bank.
// Polarity and priority encodings are used as parameter values by the bank and its filters.
package sr_latch_pkg;

  localparam logic ACT_HIGH = 1'b0;
  localparam logic ACT_LOW  = 1'b1;

  localparam logic PRIO_CLR = 1'b0;
  localparam logic PRIO_SET = 1'b1;

  // Counter must be able to hold DB_CNT itself, hence the +1.
  function automatic int db_cnt_w(input int db_cnt);
    return (db_cnt < 1) ? 1 : $clog2(db_cnt + 1);
  endfunction

endpackage

// File: rtl/sr_latch_bank_db_filter.sv
// One button input: 2-FF synchroniser, polarity normalisation and a tick-qualified
// debounce counter. OUT is the debounced input, always active-high.
module db_filter
  import sr_latch_pkg::*;
#(
  parameter int   DB_CNT     = 4,
  parameter logic ACTIVE_LOW = ACT_LOW
) (
  input  logic CLK,
  input  logic RST,
  input  logic TICK,
  input  logic IN,
  output logic OUT
);

  localparam int CW = db_cnt_w(DB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          act;
  logic          db_d;
  logic          db_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  assign act = sync2_q ^ ACTIVE_LOW;

  // Comparing against DB_CNT-1 is equivalent to "incremented value reaches DB_CNT".
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (TICK) begin
      if (act == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        db_d  = ~db_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= IN;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT = db_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N_CH debounced set/reset latches with complementary LED outputs.
// A free-running prescaler supplies the debounce tick; everything runs on CLK.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int   N_CH       = 2,
  parameter int   DIV_W      = 12,
  parameter int   DB_CNT     = 4,
  parameter logic SET_DOM    = PRIO_SET,
  parameter logic ACTIVE_LOW = ACT_LOW,
  parameter logic RST_Q      = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] SET_IN,
  input  logic [N_CH-1:0] CLR_IN,
  output logic [N_CH-1:0] Q,
  output logic [N_CH-1:0] QN,
  output logic [N_CH-1:0] CHG,
  output logic            TICK
);

  localparam logic [DIV_W-1:0] DIV_MAX = '1;

  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [N_CH-1:0]  set_db;
  logic [N_CH-1:0]  clr_db;
  logic [N_CH-1:0]  q_d;
  logic [N_CH-1:0]  q_q;
  logic [N_CH-1:0]  qn_d;
  logic [N_CH-1:0]  qn_q;
  logic [N_CH-1:0]  chg_d;
  logic [N_CH-1:0]  chg_q;

  assign div_d = div_q + 1'b1;
  assign tick  = (div_q == DIV_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      db_filter #(
        .DB_CNT     (DB_CNT),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_set_db (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick),
        .IN   (SET_IN[gi]),
        .OUT  (set_db[gi])
      );

      db_filter #(
        .DB_CNT     (DB_CNT),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_clr_db (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick),
        .IN   (CLR_IN[gi]),
        .OUT  (clr_db[gi])
      );
    end
  endgenerate

  // Level-sensitive latch: a held button keeps forcing the output every cycle.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < N_CH; i++) begin
      case ({set_db[i], clr_db[i]})
        2'b11:   q_d[i] = SET_DOM;
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        default: q_d[i] = q_q[i];
      endcase
    end
    qn_d  = ~q_d;
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q <= '0;
      q_q   <= {N_CH{RST_Q}};
      qn_q  <= {N_CH{~RST_Q}};
      chg_q <= '0;
    end else begin
      div_q <= div_d;
      q_q   <= q_d;
      qn_q  <= qn_d;
      chg_q <= chg_d;
    end
  end

  assign Q    = q_q;
  assign QN   = qn_q;
  assign CHG  = chg_q;
  assign TICK = tick;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: two instances (set-dominant and clear-dominant)
// share the same button stimulus; k counts CLK edges since the latest reset release.
module tb_sr_latch_bank;

  logic       clk;
  logic       rst;
  logic [1:0] set_in;
  logic [1:0] clr_in;
  logic [1:0] q_s, qn_s, chg_s;
  logic [1:0] q_c, qn_c, chg_c;
  logic       tick_s, tick_c;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;

  logic f_chg0_s, f_chg1_s, f_chg0_c, f_q0lo_s, f_q0hi_s, f_q0hi_c;

  sr_latch_bank #(
    .N_CH(2), .DIV_W(2), .DB_CNT(3), .SET_DOM(1'b1), .ACTIVE_LOW(1'b1), .RST_Q(1'b0)
  ) dut (
    .CLK(clk), .RST(rst), .SET_IN(set_in), .CLR_IN(clr_in),
    .Q(q_s), .QN(qn_s), .CHG(chg_s), .TICK(tick_s)
  );

  sr_latch_bank #(
    .N_CH(2), .DIV_W(2), .DB_CNT(3), .SET_DOM(1'b0), .ACTIVE_LOW(1'b1), .RST_Q(1'b0)
  ) dut_c (
    .CLK(clk), .RST(rst), .SET_IN(set_in), .CLR_IN(clr_in),
    .Q(q_c), .QN(qn_c), .CHG(chg_c), .TICK(tick_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end else begin
      $display("ok   %s: %0h (k=%0d)", tag, got, k);
    end
  endtask

  task automatic clear_flags();
    f_chg0_s = 0; f_chg1_s = 0; f_chg0_c = 0;
    f_q0lo_s = 0; f_q0hi_s = 0; f_q0hi_c = 0;
  endtask

  // Advance to the negedge following edge 'target', accumulating watch flags.
  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
      f_chg0_s |= chg_s[0];
      f_chg1_s |= chg_s[1];
      f_chg0_c |= chg_c[0];
      f_q0lo_s |= ~q_s[0];
      f_q0hi_s |= q_s[0];
      f_q0hi_c |= q_c[0];
    end
  endtask

  initial begin
    rst    = 1'b1;
    set_in = 2'b11;
    clr_in = 2'b11;
    clear_flags();

    // Reset state
    @(negedge clk);
    check_val("rst_q",    {30'd0, q_s},   32'h0);
    check_val("rst_qn",   {30'd0, qn_s},  32'h3);
    check_val("rst_chg",  {30'd0, chg_s}, 32'h0);
    check_val("rst_tick", {31'd0, tick_s}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;

    // Set channel 0: sync at edges 1,2; ticks at 4,8,12; Q rises at edge 13
    set_in[0] = 1'b0;
    adv_to(3);
    check_val("tick_at3", {31'd0, tick_s}, 32'h1);
    adv_to(4);
    check_val("tick_at4", {31'd0, tick_s}, 32'h0);
    adv_to(12);
    check_val("set0_q_before", {30'd0, q_s}, 32'h0);
    adv_to(13);
    check_val("set0_q",   {30'd0, q_s},   32'h1);
    check_val("set0_qn",  {30'd0, qn_s},  32'h2);
    check_val("set0_chg", {30'd0, chg_s}, 32'h1);
    adv_to(14);
    check_val("set0_chg_end", {30'd0, chg_s}, 32'h0);
    set_in[0] = 1'b1;

    // Glitch on SET_IN[1]: low for ticks 20,24 only, then released
    adv_to(16);
    clear_flags();
    set_in[1] = 1'b0;
    adv_to(24);
    set_in[1] = 1'b1;
    adv_to(40);
    check_val("glitch_q1",      {31'd0, q_s[1]},   32'h0);
    check_val("glitch_chg1",    {31'd0, f_chg1_s}, 32'h0);
    check_val("glitch_q0_hold", {31'd0, q_s[0]},   32'h1);

    // Both held on channel 0: ticks 44,48,52 -> priority decides at edge 53
    set_in[0] = 1'b0;
    clr_in[0] = 1'b0;
    adv_to(53);
    check_val("both_setdom_q", {31'd0, q_s[0]},   32'h1);
    check_val("both_setdom_c", {31'd0, chg_s[0]}, 32'h0);
    check_val("both_clrdom_q", {31'd0, q_c[0]},   32'h0);
    check_val("both_clrdom_c", {31'd0, chg_c[0]}, 32'h1);
    clear_flags();
    adv_to(70);
    check_val("both_setdom_stable", {31'd0, f_q0lo_s}, 32'h0);
    check_val("both_clrdom_stable", {31'd0, f_q0hi_c | f_chg0_c}, 32'h0);
    set_in[0] = 1'b1;
    clr_in[0] = 1'b1;

    // Both released (debounced inactive at 84); Q holds, then clear pulse at 88
    adv_to(88);
    check_val("release_hold", {31'd0, q_s[0]}, 32'h1);
    clr_in[0] = 1'b0;
    adv_to(100);
    check_val("clr_q_before", {31'd0, q_s[0]}, 32'h1);
    adv_to(101);
    check_val("clr_q",   {31'd0, q_s[0]},  32'h0);
    check_val("clr_qn",  {31'd0, qn_s[0]}, 32'h1);
    check_val("clr_chg", {31'd0, chg_s[0]}, 32'h1);
    adv_to(102);
    clear_flags();
    adv_to(104);
    clr_in[0] = 1'b1;
    adv_to(510);
    check_val("idle_q0_stays_0", {31'd0, f_q0hi_s}, 32'h0);
    check_val("idle_no_chg0",    {31'd0, f_chg0_s}, 32'h0);

    // Reset mid-debounce (count at 2 after edge 528)
    adv_to(520);
    set_in[0] = 1'b0;
    adv_to(530);
    rst = 1'b1;
    #1;
    check_val("mid_rst_q",  {30'd0, q_s},  32'h0);
    check_val("mid_rst_qn", {30'd0, qn_s}, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    adv_to(12);
    check_val("requal_q_before", {31'd0, q_s[0]}, 32'h0);
    adv_to(13);
    check_val("requal_q",   {31'd0, q_s[0]},   32'h1);
    check_val("requal_chg", {31'd0, chg_s[0]}, 32'h1);

    // Asynchronous reset with no clock edge
    adv_to(20);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_q",     {30'd0, q_s},   32'h0);
    check_val("async_qn",    {30'd0, qn_s},  32'h3);
    check_val("async_chg",   {30'd0, chg_s}, 32'h0);
    check_val("async_q_c",   {30'd0, q_c},   32'h0);
    check_val("async_qn_c",  {30'd0, qn_c},  32'h3);
    check_val("async_tick_c", {31'd0, tick_c}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
